// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared ROB sizing, CDB source IDs and counter-width helper
package cdb_arbiter_pkg;
    localparam int ROB_POS_WID = 4;
    localparam int ROB_SIZE    = 1 << ROB_POS_WID;
    typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: ALU/LSB result offers in, ready back, registered CDB broadcast out
//   master: producer/consumer side (drives *_valid and payloads, sees ready and cdb_*)
//   slave : arbiter side (sees offers, drives *_ready and cdb_*)
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(parameter int ROB_POS_W = ROB_POS_WID);
    logic                 alu_valid;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic [31:0]          alu_val;
    logic                 alu_jump;
    logic [31:0]          alu_pc;
    logic                 alu_ready;
    logic                 lsb_valid;
    logic [ROB_POS_W-1:0] lsb_rob_pos;
    logic [31:0]          lsb_val;
    logic                 lsb_ready;
    logic                 cdb_valid;
    logic                 cdb_src;
    logic [ROB_POS_W-1:0] cdb_rob_pos;
    logic [31:0]          cdb_val;
    logic                 cdb_jump;
    logic [31:0]          cdb_pc;
    modport master (
        output alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc, lsb_valid, lsb_rob_pos, lsb_val,
        input  alu_ready, lsb_ready, cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
    );
    modport slave (
        input  alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc, lsb_valid, lsb_rob_pos, lsb_val,
        output alu_ready, lsb_ready, cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
    );
endinterface

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: D-entry FIFO with enable freeze and synchronous flush
//   clk, rst_n : clock, async active-low reset
//   en         : global enable, all state frozen when low
//   flush      : synchronous clear of pointers and count (when en)
//   push/din   : write (caller guarantees not full)
//   pop        : read (caller guarantees not empty)
//   dout/count : head entry (comb from storage) and occupancy
module cdb_fifo #(
    parameter int W  = 8,
    parameter int D  = 2,
    parameter int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(D);
    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (en && push && !flush) mem[wr_ptr] <= din;
    // D is a power of two, so pointers wrap naturally on overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin merge of ALU and LSB results onto one registered CDB
//   clk, rst_n : clock, async active-low reset
//   rdy        : global enable, low freezes everything
//   rollback   : flush both queues and drop this cycle's offers
//   bus        : ALU/LSB offers and ready, cdb_* broadcast (see cdb_arbiter_if)
module cdb_arbiter import cdb_arbiter_pkg::*; #(
    parameter int ROB_POS_W = ROB_POS_WID,
    parameter int QDEPTH    = 2
) (
    input logic            clk,
    input logic            rst_n,
    input logic            rdy,
    input logic            rollback,
    cdb_arbiter_if.slave   bus
);
    localparam int CW = cnt_w(QDEPTH);
    localparam int AW = 65 + ROB_POS_W;
    localparam int LW = 32 + ROB_POS_W;
    logic [CW-1:0] alu_cnt, lsb_cnt;
    logic [AW-1:0] alu_head;
    logic [LW-1:0] lsb_head;
    logic          alu_push, lsb_push, alu_pop, lsb_pop, a_has, l_has, gnt_lsb, go;
    src_e          last_grant;
    assign bus.alu_ready = rdy && (alu_cnt < CW'(QDEPTH));
    assign bus.lsb_ready = rdy && (lsb_cnt < CW'(QDEPTH));
    assign go       = rdy && !rollback;
    assign alu_push = bus.alu_valid && bus.alu_ready && !rollback;
    assign lsb_push = bus.lsb_valid && bus.lsb_ready && !rollback;
    assign a_has    = alu_cnt != '0;
    assign l_has    = lsb_cnt != '0;
    // On a tie the source that lost last time wins; otherwise whoever has data
    assign gnt_lsb  = l_has && (!a_has || last_grant == SRC_ALU);
    assign alu_pop  = go && a_has && !gnt_lsb;
    assign lsb_pop  = go && gnt_lsb;
    cdb_fifo #(.W(AW), .D(QDEPTH), .CW(CW)) u_alu_q (
        .clk(clk), .rst_n(rst_n), .en(rdy), .flush(rollback), .push(alu_push),
        .din({bus.alu_jump, bus.alu_pc, bus.alu_val, bus.alu_rob_pos}),
        .pop(alu_pop), .dout(alu_head), .count(alu_cnt)
    );
    cdb_fifo #(.W(LW), .D(QDEPTH), .CW(CW)) u_lsb_q (
        .clk(clk), .rst_n(rst_n), .en(rdy), .flush(rollback), .push(lsb_push),
        .din({bus.lsb_val, bus.lsb_rob_pos}),
        .pop(lsb_pop), .dout(lsb_head), .count(lsb_cnt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant      <= SRC_LSB;
            bus.cdb_valid   <= 1'b0;
            bus.cdb_src     <= 1'b0;
            bus.cdb_rob_pos <= '0;
            bus.cdb_val     <= '0;
            bus.cdb_jump    <= 1'b0;
            bus.cdb_pc      <= '0;
        end else if (rdy) begin
            bus.cdb_valid <= go && (a_has || l_has);
            if (go && (a_has || l_has)) begin
                last_grant      <= src_e'(gnt_lsb);
                bus.cdb_src     <= gnt_lsb;
                bus.cdb_rob_pos <= gnt_lsb ? lsb_head[ROB_POS_W-1:0] : alu_head[ROB_POS_W-1:0];
                bus.cdb_val     <= gnt_lsb ? lsb_head[ROB_POS_W +: 32] : alu_head[ROB_POS_W +: 32];
                bus.cdb_pc      <= gnt_lsb ? 32'd0 : alu_head[ROB_POS_W+32 +: 32];
                bus.cdb_jump    <= !gnt_lsb && alu_head[ROB_POS_W+64];
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed + random stimulus against a queue-based reference model
module tb_cdb_arbiter;
    localparam int PW = 4;
    localparam int QD = 2;
    typedef struct {
        logic [PW-1:0] pos;
        logic [31:0]   val;
        logic          jump;
        logic [31:0]   pc;
    } ent_t;
    logic clk = 0, rst_n = 0, rdy = 1, rollback = 0;
    int   checks = 0, failures = 0;
    ent_t aq[$], lq[$];
    bit   m_last = 1;
    bit   e_valid = 0, e_src = 0;
    ent_t e_ent, z;
    cdb_arbiter_if #(.ROB_POS_W(PW)) bus();
    cdb_arbiter #(.ROB_POS_W(PW), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback), .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus.cdb_valid, 0);
        chk({tag, "_src"}, bus.cdb_src, 0);
        chk({tag, "_pos"}, bus.cdb_rob_pos, 0);
        chk({tag, "_val"}, bus.cdb_val, 0);
        chk({tag, "_jump"}, bus.cdb_jump, 0);
        chk({tag, "_pc"}, bus.cdb_pc, 0);
        chk({tag, "_aready"}, bus.alu_ready, 1);
        chk({tag, "_lready"}, bus.lsb_ready, 1);
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.pos = PW'($urandom);
        e.val = $urandom;
        e.jump = 1'($urandom);
        e.pc = $urandom;
        return e;
    endfunction

    // One clock: drive at edge+1, check ready mid-cycle, advance model, check cdb at next edge+1
    task automatic step(input string tag, input bit r, input bit rb,
                        input bit av, input ent_t a, input bit lv, input ent_t l);
        bit ar, lr;
        rdy = r;
        rollback = rb;
        bus.alu_valid = av;
        bus.alu_rob_pos = a.pos;
        bus.alu_val = a.val;
        bus.alu_jump = a.jump;
        bus.alu_pc = a.pc;
        bus.lsb_valid = lv;
        bus.lsb_rob_pos = l.pos;
        bus.lsb_val = l.val;
        #4;
        ar = r && aq.size() < QD;
        lr = r && lq.size() < QD;
        chk({tag, "_aready"}, bus.alu_ready, ar);
        chk({tag, "_lready"}, bus.lsb_ready, lr);
        if (r) begin
            if (rb) begin
                aq.delete();
                lq.delete();
                e_valid = 0;
            end else begin
                e_valid = aq.size() > 0 || lq.size() > 0;
                if (e_valid) begin
                    if (aq.size() > 0 && lq.size() > 0) e_src = !m_last;
                    else e_src = lq.size() > 0;
                    m_last = e_src;
                    if (e_src) begin
                        e_ent = lq.pop_front();
                        e_ent.jump = 0;
                        e_ent.pc = 0;
                    end else e_ent = aq.pop_front();
                end
                if (av && ar) aq.push_back(a);
                if (lv && lr) lq.push_back(ent_t'{l.pos, l.val, 1'b0, 32'd0});
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, bus.cdb_valid, e_valid);
        if (e_valid) begin
            chk({tag, "_src"}, bus.cdb_src, e_src);
            chk({tag, "_pos"}, bus.cdb_rob_pos, e_ent.pos);
            chk({tag, "_val"}, bus.cdb_val, e_ent.val);
            chk({tag, "_jump"}, bus.cdb_jump, e_ent.jump);
            chk({tag, "_pc"}, bus.cdb_pc, e_ent.pc);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 0, 0, z, 0, z);
    endtask

    initial begin
        z = '{default: 0};
        bus.alu_valid = 0;
        bus.alu_rob_pos = 0;
        bus.alu_val = 0;
        bus.alu_jump = 0;
        bus.alu_pc = 0;
        bus.lsb_valid = 0;
        bus.lsb_rob_pos = 0;
        bus.lsb_val = 0;
        #3;
        chk_zero("reset");
        rst_n = 1;
        @(posedge clk);
        #1;
        // single ALU result: one-edge latency, then back to idle
        step("single_push", 1, 0, 1, '{4'd3, 32'h11, 1'b1, 32'h100}, 0, z);
        idle("single_out", 2);
        // simultaneous offers, tie then repeat
        step("tie1", 1, 0, 1, '{4'd1, 32'hA1, 1'b0, 32'h40}, 1, '{4'd2, 32'hB2, 1'b0, 32'h0});
        idle("tie1_out", 3);
        step("tie2", 1, 0, 1, '{4'd1, 32'hA3, 1'b1, 32'h44}, 1, '{4'd2, 32'hB4, 1'b0, 32'h0});
        idle("tie2_out", 3);
        // ALU back-to-back while LSB saturates: queues fill, ready drops, nothing lost
        for (int i = 0; i < 6; i++) step("sat", 1, 0, 1, rnd_ent(), 1, rnd_ent());
        idle("sat_drain", 6);
        // rollback with entries queued drops them and same-cycle offers
        step("rb_fill", 1, 0, 1, rnd_ent(), 1, rnd_ent());
        step("rb_fill2", 1, 0, 1, rnd_ent(), 1, rnd_ent());
        step("rollback", 1, 1, 1, rnd_ent(), 1, rnd_ent());
        idle("rb_after", 3);
        // freeze with a live broadcast of pos 5
        step("frz_fill", 1, 0, 1, '{4'd5, 32'h55, 1'b0, 32'h500}, 1, rnd_ent());
        step("frz_fill2", 1, 0, 1, rnd_ent(), 0, z);
        for (int i = 0; i < 3; i++) step("freeze", 0, 1, 1, rnd_ent(), 1, rnd_ent());
        idle("frz_drain", 4);
        // async reset mid-cycle with queued entries
        step("ar_fill", 1, 0, 1, rnd_ent(), 1, rnd_ent());
        step("ar_fill2", 1, 0, 1, rnd_ent(), 1, rnd_ent());
        #2;
        rst_n = 0;
        #1;
        chk_zero("async_rst");
        aq.delete();
        lq.delete();
        m_last = 1;
        e_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        idle("post_rst", 3);
        step("post_rst_push", 1, 0, 1, '{4'd7, 32'h77, 1'b1, 32'h700}, 0, z);
        idle("post_rst_out", 2);
        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", $urandom_range(7) != 0, $urandom_range(19) == 0,
                 $urandom_range(9) < 6, rnd_ent(), $urandom_range(9) < 6, rnd_ent());
        idle("final_drain", 6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
